mem_bus_fabric: RTL and testbench

//  Parametrised 1-master / NUM_SLAVES-slave interconnect for the picorv32 native memory bus
//  (valid/ready, 32-bit addr/data, 4-bit wstrb). Decodes by per-slave base/mask and forwards one

---
 rtl/mem_bus_fabric_pkg.sv | 50 +++++
 rtl/mem_bus_fabric_decoder.sv | 27 ++
 rtl/mem_bus_fabric.sv | 156 +++++++++++++++
 tb/tb_mem_bus_fabric.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_fabric_pkg.sv
// Shared types, defaults and the standard system address map for the memory bus fabric.
package mem_bus_fabric_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERROR  = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Request payload latched from the master and broadcast to all slaves
    typedef struct packed {
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

    localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    // Standard system map: RAM low/high banks, out_byte port, UART
    localparam logic [ADDR_W-1:0] MAP_RAM_LO_BASE = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] MAP_RAM_LO_MASK = 32'hFFFF_F000;
    localparam logic [ADDR_W-1:0] MAP_RAM_HI_BASE = 32'h0000_1000;
    localparam logic [ADDR_W-1:0] MAP_RAM_HI_MASK = 32'hFFFF_F000;
    localparam logic [ADDR_W-1:0] MAP_OUTB_BASE   = 32'h1000_0000;
    localparam logic [ADDR_W-1:0] MAP_OUTB_MASK   = 32'hFFFF_FFF0;
    localparam logic [ADDR_W-1:0] MAP_UART_BASE   = 32'h1000_0010;
    localparam logic [ADDR_W-1:0] MAP_UART_MASK   = 32'hFFFF_FFF0;

    localparam logic [4*ADDR_W-1:0] DEF_SLV_BASE =
        {MAP_UART_BASE, MAP_OUTB_BASE, MAP_RAM_HI_BASE, MAP_RAM_LO_BASE};
    localparam logic [4*ADDR_W-1:0] DEF_SLV_MASK =
        {MAP_UART_MASK, MAP_OUTB_MASK, MAP_RAM_HI_MASK, MAP_RAM_LO_MASK};

    // Index width needed to name one of n slaves (at least one bit)
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // picorv32 encodes a read as all strobes low
    function automatic logic is_read(input logic [STRB_W-1:0] wstrb);
        return (wstrb == '0);
    endfunction

endpackage

// File: rtl/mem_bus_fabric_decoder.sv
// Address decoder: base/mask compare per slave, lowest index wins on overlap.
module mem_bus_fabric_decoder
    import mem_bus_fabric_pkg::*;
#(
    parameter int unsigned              NUM_SLAVES = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLV_BASE   = DEF_SLV_BASE,
    parameter logic [32*NUM_SLAVES-1:0] SLV_MASK   = DEF_SLV_MASK,
    localparam int unsigned             SEL_W      = sel_width(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_c_o,
    output logic [SEL_W-1:0]  sel_c_o
);

    // Scan from the highest index down so the lowest matching slave is the last write
    always_comb begin
        hit_c_o = 1'b0;
        sel_c_o = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if ((addr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit_c_o = 1'b1;
                sel_c_o = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_fabric.sv
// 1-master / N-slave picorv32 native bus fabric with registered request/response and timeout.
module mem_bus_fabric
    import mem_bus_fabric_pkg::*;
#(
    parameter int unsigned              NUM_SLAVES = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLV_BASE   = DEF_SLV_BASE,
    parameter logic [32*NUM_SLAVES-1:0] SLV_MASK   = DEF_SLV_MASK,
    parameter int unsigned              TIMEOUT    = 255,
    parameter logic [DATA_W-1:0]        ERR_DATA   = ERR_DATA_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         m_valid_i,
    input  logic                         m_instr_i,
    input  logic [ADDR_W-1:0]            m_addr_i,
    input  logic [DATA_W-1:0]            m_wdata_i,
    input  logic [STRB_W-1:0]            m_wstrb_i,
    output logic                         m_ready_o,
    output logic [DATA_W-1:0]            m_rdata_o,
    output logic [NUM_SLAVES-1:0]        s_valid_o,
    output logic                         s_instr_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W-1:0]            s_wdata_o,
    output logic [STRB_W-1:0]            s_wstrb_o,
    input  logic [NUM_SLAVES-1:0]        s_ready_i,
    input  logic [DATA_W*NUM_SLAVES-1:0] s_rdata_i,
    output logic                         err_o,
    output logic [ADDR_W-1:0]            err_addr_o
);

    localparam int unsigned SEL_W = sel_width(NUM_SLAVES);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e                  state_q, state_d;
    mem_req_t                req_q, req_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [NUM_SLAVES-1:0]   s_valid_q, s_valid_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    m_ready_q, m_ready_d;
    logic [DATA_W-1:0]       m_rdata_q, m_rdata_d;
    logic                    err_q, err_d;
    logic [ADDR_W-1:0]       err_addr_q, err_addr_d;

    logic                    dec_hit;
    logic [SEL_W-1:0]        dec_sel;
    logic                    slv_ready;
    logic [DATA_W-1:0]       slv_rdata;
    logic                    timeout_hit;

    mem_bus_fabric_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decoder (
        .addr_i  (m_addr_i),
        .hit_c_o (dec_hit),
        .sel_c_o (dec_sel)
    );

    // Only the selected slave's handshake and data are observed
    assign slv_ready   = s_ready_i[sel_q];
    assign slv_rdata   = s_rdata_i[DATA_W*32'(sel_q) +: DATA_W];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        sel_d      = sel_q;
        s_valid_d  = s_valid_q;
        cnt_d      = cnt_q;
        m_ready_d  = 1'b0;
        m_rdata_d  = m_rdata_q;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (m_valid_i && !m_ready_q) begin
                    req_d = '{instr: m_instr_i, addr: m_addr_i, wdata: m_wdata_i, wstrb: m_wstrb_i};
                    sel_d = dec_sel;
                    cnt_d = '0;
                    if (dec_hit) begin
                        s_valid_d = NUM_SLAVES'(1) << dec_sel;
                        state_d   = ST_ACCESS;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (slv_ready) begin
                    s_valid_d = '0;
                    m_ready_d = 1'b1;
                    m_rdata_d = is_read(req_q.wstrb) ? slv_rdata : '0;
                    state_d   = ST_RESP;
                end else if (timeout_hit) begin
                    s_valid_d  = '0;
                    m_ready_d  = 1'b1;
                    err_d      = 1'b1;
                    err_addr_d = req_q.addr;
                    m_rdata_d  = is_read(req_q.wstrb) ? ERR_DATA : '0;
                    state_d    = ST_RESP;
                end
            end
            ST_ERROR: begin
                m_ready_d  = 1'b1;
                err_d      = 1'b1;
                err_addr_d = req_q.addr;
                m_rdata_d  = is_read(req_q.wstrb) ? ERR_DATA : '0;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            sel_q      <= '0;
            s_valid_q  <= '0;
            cnt_q      <= '0;
            m_ready_q  <= 1'b0;
            m_rdata_q  <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            sel_q      <= sel_d;
            s_valid_q  <= s_valid_d;
            cnt_q      <= cnt_d;
            m_ready_q  <= m_ready_d;
            m_rdata_q  <= m_rdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign m_ready_o  = m_ready_q;
    assign m_rdata_o  = m_rdata_q;
    assign s_valid_o  = s_valid_q;
    assign s_instr_o  = req_q.instr;
    assign s_addr_o   = req_q.addr;
    assign s_wdata_o  = req_q.wdata;
    assign s_wstrb_o  = req_q.wstrb;
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Randomised self-checking bench for mem_bus_fabric against a transaction-level model.
module tb_mem_bus_fabric;

    localparam int unsigned NS = 4;
    localparam int unsigned TO = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    // Slave 1 overlaps slave 0 (and extends to 0xFFFF) to exercise priority
    localparam logic [32*NS-1:0] TB_BASE = {32'h1000_0010, 32'h1000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic [32*NS-1:0] TB_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFFF_F000};

    logic [31:0] map_base [NS] = '{32'h0000_0000, 32'h0000_0000, 32'h1000_0000, 32'h1000_0010};
    logic [31:0] map_mask [NS] = '{32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

    logic            clk;
    logic            rst_i;
    logic            m_valid_i;
    logic            m_instr_i;
    logic [31:0]     m_addr_i;
    logic [31:0]     m_wdata_i;
    logic [3:0]      m_wstrb_i;
    logic            m_ready_o;
    logic [31:0]     m_rdata_o;
    logic [NS-1:0]   s_valid_o;
    logic            s_instr_o;
    logic [31:0]     s_addr_o;
    logic [31:0]     s_wdata_o;
    logic [3:0]      s_wstrb_o;
    logic [NS-1:0]   s_ready_i;
    logic [32*NS-1:0] s_rdata_i;
    logic            err_o;
    logic [31:0]     err_addr_o;

    int          tests  = 0;
    int          failed = 0;
    longint      cyc    = 0;
    longint      last_ready_cyc = 0;
    logic [31:0] exp_err_addr = 32'h0;

    mem_bus_fabric #(
        .NUM_SLAVES (NS),
        .SLV_BASE   (TB_BASE),
        .SLV_MASK   (TB_MASK),
        .TIMEOUT    (TO),
        .ERR_DATA   (ERR)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .m_valid_i  (m_valid_i),
        .m_instr_i  (m_instr_i),
        .m_addr_i   (m_addr_i),
        .m_wdata_i  (m_wdata_i),
        .m_wstrb_i  (m_wstrb_i),
        .m_ready_o  (m_ready_o),
        .m_rdata_o  (m_rdata_o),
        .s_valid_o  (s_valid_o),
        .s_instr_o  (s_instr_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_wstrb_o  (s_wstrb_o),
        .s_ready_i  (s_ready_i),
        .s_rdata_i  (s_rdata_i),
        .err_o      (err_o),
        .err_addr_o (err_addr_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // First slave in index order whose region contains the address, -1 if none
    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < int'(NS); i++)
            if ((a & map_mask[i]) == map_base[i]) return i;
        return -1;
    endfunction

    // One master transaction; must be called at a negedge. The slave answers
    // after k full cycles of s_valid (ready in the (k+1)th s_valid cycle).
    // stray: 0 = other readies low, 1 = random, 2 = all high.
    task automatic run_txn(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic instr, input int k, input int stray);
        int          sel;
        int          exp_lat;
        int          exp_sv;
        int          sv_cnt;
        int          err_cnt;
        int          lat;
        bit          done;
        bit          bad_req;
        bit          bad_sel;
        bit          is_err;
        logic [31:0] slv_data [NS];
        logic [31:0] exp_data;
        logic [NS-1:0] exp_oh;
        logic [NS-1:0] rdy;

        sel = model_decode(addr);
        for (int i = 0; i < int'(NS); i++) begin
            slv_data[i] = $urandom;
            s_rdata_i[32*i +: 32] = slv_data[i];
        end
        is_err = (sel < 0) || (k >= int'(TO));
        exp_oh = '0;
        if (sel >= 0) exp_oh[sel] = 1'b1;
        if (sel < 0) begin
            exp_lat = 2;        exp_sv = 0;
        end else if (is_err) begin
            exp_lat = TO + 1;   exp_sv = TO;
        end else begin
            exp_lat = k + 2;    exp_sv = k + 1;
        end
        if (is_err) exp_data = (wstrb == 4'b0) ? ERR : 32'h0;
        else        exp_data = (wstrb == 4'b0) ? slv_data[sel] : 32'h0;
        if (is_err) exp_err_addr = addr;

        m_valid_i = 1'b1; m_addr_i = addr; m_wdata_i = wdata; m_wstrb_i = wstrb; m_instr_i = instr;
        sv_cnt = 0; err_cnt = 0; done = 0; bad_req = 0; bad_sel = 0; lat = 0;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            if (err_o) err_cnt++;
            if (s_valid_o != '0) begin
                sv_cnt++;
                if (s_valid_o !== exp_oh) bad_sel = 1;
                if (s_addr_o !== addr || s_wdata_o !== wdata || s_wstrb_o !== wstrb || s_instr_o !== instr)
                    bad_req = 1;
            end
            if (m_ready_o === 1'b1) begin
                done = 1;
                lat = c;
                last_ready_cyc = cyc;
                tests++;
                if (m_rdata_o !== exp_data) begin
                    failed++;
                    $display("FAIL %s rdata: got %08h want %08h", name, m_rdata_o, exp_data);
                end
                tests++;
                if (err_addr_o !== exp_err_addr) begin
                    failed++;
                    $display("FAIL %s err_addr: got %08h want %08h", name, err_addr_o, exp_err_addr);
                end
                m_valid_i = 1'b0;
                s_ready_i = '0;
            end else begin
                rdy = '0;
                if (stray == 1) rdy = 4'($urandom);
                else if (stray == 2) rdy = '1;
                if (sel >= 0) rdy[sel] = s_valid_o[sel] && (sv_cnt == k + 1);
                s_ready_i = rdy;
            end
        end

        tests++;
        if (!done) begin
            failed++;
            $display("FAIL %s handshake: got no m_ready in 60 cycles want latency %0d", name, exp_lat);
            m_valid_i = 1'b0;
            s_ready_i = '0;
        end else begin
            tests++;
            if (lat != exp_lat) begin
                failed++;
                $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
            end
            tests++;
            if (sv_cnt != exp_sv || bad_sel) begin
                failed++;
                $display("FAIL %s s_valid: got %0d cycles (wrong slave=%0d) want %0d cycles onehot %b",
                         name, sv_cnt, bad_sel, exp_sv, exp_oh);
            end
            tests++;
            if (bad_req) begin
                failed++;
                $display("FAIL %s request: got unstable or wrong s_* want addr %08h wdata %08h wstrb %b",
                         name, addr, wdata, wstrb);
            end
            tests++;
            if (err_cnt != (is_err ? 1 : 0)) begin
                failed++;
                $display("FAIL %s err pulses: got %0d want %0d", name, err_cnt, is_err ? 1 : 0);
            end
            @(negedge clk);
            tests++;
            if (m_ready_o !== 1'b0 || err_o !== 1'b0 || s_valid_o !== '0 || m_rdata_o !== exp_data) begin
                failed++;
                $display("FAIL %s hold: got ready %b err %b s_valid %b rdata %08h want 0 0 0 %08h",
                         name, m_ready_o, err_o, s_valid_o, m_rdata_o, exp_data);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        m_valid_i = 1'b1; m_addr_i = 32'h40;
        repeat (3) @(negedge clk);
        tests++;
        if (m_ready_o !== 1'b0 || err_o !== 1'b0 || s_valid_o !== '0) begin
            failed++;
            $display("FAIL reset ctrl: got ready %b err %b s_valid %b want all 0", m_ready_o, err_o, s_valid_o);
        end
        tests++;
        if (m_rdata_o !== 32'h0 || err_addr_o !== 32'h0) begin
            failed++;
            $display("FAIL reset data: got rdata %08h err_addr %08h want 0", m_rdata_o, err_addr_o);
        end
        tests++;
        if ({s_instr_o, s_addr_o, s_wdata_o, s_wstrb_o} !== '0) begin
            failed++;
            $display("FAIL reset req: got instr %b addr %08h wdata %08h wstrb %b want 0",
                     s_instr_o, s_addr_o, s_wdata_o, s_wstrb_o);
        end
        m_valid_i = 1'b0;
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_txn("rd_slave0",     32'h0000_0040, 32'h0,  4'b0000, 1'b0, 1,   0);
        run_txn("wr_slave2",     32'h1000_0000, 32'hA5, 4'b0001, 1'b0, 1,   0);
        run_txn("miss",          32'h2000_0000, 32'h0,  4'b0000, 1'b0, 1,   1);
        run_txn("timeout_rd",    32'h1000_0004, 32'h0,  4'b0000, 1'b0, 100, 0);
        run_txn("timeout_wr",    32'h1000_0008, 32'h77, 4'b1111, 1'b0, 100, 1);
        run_txn("overlap",       32'h0000_0080, 32'h0,  4'b0000, 1'b1, 3,   2);
        run_txn("ready_at_last", 32'h1000_0018, 32'h0,  4'b0000, 1'b0, 7,   0);
        run_txn("timeout_edge",  32'h1000_001C, 32'h0,  4'b0000, 1'b0, 8,   0);
        run_txn("wr_miss",       32'hF000_0000, 32'h1,  4'b1100, 1'b0, 1,   0);
    endtask

    task automatic test_back_to_back();
        longint first;
        run_txn("b2b_a", 32'h0000_1234, 32'h0,  4'b0000, 1'b0, 2, 0);
        first = last_ready_cyc;
        run_txn("b2b_b", 32'h0000_0010, 32'h5A, 4'b0011, 1'b0, 4, 1);
        tests++;
        if (last_ready_cyc - first != 64'(4 + 3)) begin
            failed++;
            $display("FAIL b2b throughput: got %0d cycles want %0d", last_ready_cyc - first, 7);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [3:0]  ws;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       a = {20'h0, 12'($urandom)};
                1:       a = 32'h0000_1000 + $urandom_range(0, 32'h0000_EFFF);
                2:       a = 32'h1000_0000 + $urandom_range(0, 15);
                3:       a = 32'h1000_0010 + $urandom_range(0, 15);
                default: a = $urandom;
            endcase
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            run_txn("random", a, $urandom, ws, 1'($urandom), int'($urandom_range(1, 10)),
                    int'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        m_valid_i = 1'b1; m_addr_i = 32'h0000_0044; m_wstrb_i = 4'b0000; m_instr_i = 1'b0;
        s_ready_i = '0;
        @(negedge clk);
        tests++;
        if (s_valid_o !== 4'b0001) begin
            failed++;
            $display("FAIL rst_mid access: got s_valid %b want 0001", s_valid_o);
        end
        rst_i = 1'b1;
        @(negedge clk);
        tests++;
        if ({m_ready_o, m_rdata_o, s_valid_o, s_instr_o, s_addr_o, s_wdata_o, s_wstrb_o, err_o, err_addr_o} !== '0) begin
            failed++;
            $display("FAIL rst_mid clear: got ready %b rdata %08h s_valid %b addr %08h err %b err_addr %08h want all 0",
                     m_ready_o, m_rdata_o, s_valid_o, s_addr_o, err_o, err_addr_o);
        end
        rst_i = 1'b0;
        m_valid_i = 1'b0;
        exp_err_addr = 32'h0;
        @(negedge clk);
        run_txn("post_reset", 32'h1000_0014, 32'h0, 4'b0000, 1'b0, 2, 0);
    endtask

    initial begin
        rst_i = 1'b1; m_valid_i = 1'b0; m_instr_i = 1'b0; m_addr_i = '0; m_wdata_i = '0;
        m_wstrb_i = '0; s_ready_i = '0; s_rdata_i = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test by 1000000 want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
